// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-segment bank driver; writes double-buffered and committed at frame boundaries.
// Outputs registered (no added latency vs. slot timing); no backpressure, a newer write simply replaces the pending one.
module seg_display_scanner #(
   parameter int NUM_DIGITS    = 4,
   parameter int TICK_DIV      = 50000,
   parameter int BLANK_CYCLES  = 16,
   parameter int DIGIT_ACT_LOW = 1,
   parameter int SEG_ACT_LOW   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic [NUM_DIGITS-1:0]   wr_dp,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start,
   output logic                    pending
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   localparam logic [NUM_DIGITS-1:0] SEL_OFF = (DIGIT_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [PW-1:0]           presc, prescNext;
   logic [IW-1:0]           idx, idxNext;
   logic                    prescWrap, frameEdge;
   logic [0:0]              slotNext;
   logic [4*NUM_DIGITS-1:0] dispDat, dispDatNext, pendDat;
   logic [NUM_DIGITS-1:0]   dispDp, dispDpNext, pendDp;
   logic [NUM_DIGITS-1:0]   lzMask;
   logic                    allZero;
   logic [3:0]              curNib;
   logic                    curDp, lzBlank;
   logic [6:0]              segActive;

   function automatic logic [6:0] decodeHex(input logic [3:0] nib);
      case (nib)
         4'h0: decodeHex = 7'h3F;
         4'h1: decodeHex = 7'h06;
         4'h2: decodeHex = 7'h5B;
         4'h3: decodeHex = 7'h4F;
         4'h4: decodeHex = 7'h66;
         4'h5: decodeHex = 7'h6D;
         4'h6: decodeHex = 7'h7D;
         4'h7: decodeHex = 7'h07;
         4'h8: decodeHex = 7'h7F;
         4'h9: decodeHex = 7'h6F;
         4'hA: decodeHex = 7'h77;
         4'hB: decodeHex = 7'h7C;
         4'hC: decodeHex = 7'h39;
         4'hD: decodeHex = 7'h5E;
         4'hE: decodeHex = 7'h79;
         default: decodeHex = 7'h71;
      endcase
   endfunction

   // Outputs are computed from next-cycle state so the registered pins line up with the prescaler.
   always_comb begin
      prescWrap = (presc == PRESC_LAST);
      prescNext = prescWrap ? '0 : presc + 1'b1;
      idxNext   = idx;
      if (prescWrap) begin
         idxNext = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      frameEdge   = prescWrap && (idx == IDX_LAST);
      dispDatNext = dispDat;
      dispDpNext  = dispDp;
      if (frameEdge) begin
         if (wr_en) begin
            dispDatNext = wr_data;
            dispDpNext  = wr_dp;
         end else if (pending) begin
            dispDatNext = pendDat;
            dispDpNext  = pendDp;
         end
      end
      slotNext = (prescNext < BLANK_END) ? ST_BLANK : ST_DRIVE;
   end

   // A digit is a leading zero when it and every more-significant nibble are zero; digit 0 never is.
   always_comb begin
      lzMask  = '0;
      allZero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         allZero   = allZero && (dispDatNext[4*k +: 4] == 4'h0);
         lzMask[k] = allZero;
      end
   end

   always_comb begin
      curNib    = dispDatNext[4*int'(idxNext) +: 4];
      curDp     = dispDpNext[idxNext];
      lzBlank   = blank_lz && lzMask[idxNext];
      segActive = lzBlank ? 7'h00 : decodeHex(curNib);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc       <= '0;
         idx         <= '0;
         dispDat     <= '0;
         dispDp      <= '0;
         pendDat     <= '0;
         pendDp      <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         digit_sel   <= SEL_OFF;
         seg         <= SEG_OFF;
         dp          <= DP_OFF;
      end else begin
         presc       <= prescNext;
         idx         <= idxNext;
         dispDat     <= dispDatNext;
         dispDp      <= dispDpNext;
         frame_start <= frameEdge;
         if (frameEdge) begin
            pending <= 1'b0;
         end else if (wr_en) begin
            pendDat <= wr_data;
            pendDp  <= wr_dp;
            pending <= 1'b1;
         end
         if (slotNext == ST_DRIVE) begin
            digit_sel <= SEL_OFF ^ (NUM_DIGITS'(1) << idxNext);
            seg       <= SEG_OFF ^ segActive;
            dp        <= DP_OFF ^ curDp;
         end else begin
            digit_sel <= SEL_OFF;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: directed corner sequences, decode table vectors and random traffic vs. a timeline model.
module tb_seg_display_scanner;

   localparam int ND    = 4;
   localparam int TD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * TD;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn;
   logic [15:0] wrData;
   logic [3:0]  wrDp;
   logic        blankLz;
   logic [3:0]  digitSel;
   logic [6:0]  seg;
   logic        dp;
   logic        frameStart;
   logic        pending;

   seg_display_scanner #(
      .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYCLES(BC), .DIGIT_ACT_LOW(1), .SEG_ACT_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wrEn), .wr_data(wrData), .wr_dp(wrDp), .blank_lz(blankLz),
      .digit_sel(digitSel), .seg(seg), .dp(dp), .frame_start(frameStart), .pending(pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: time since reset release plus the two buffers, active-high glyphs.
   logic [6:0]  decTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          t;
   logic [15:0] mDisp, mPend;
   logic [3:0]  mDispDp, mPendDp;
   logic        mPendFlag, mFrame;

   typedef struct {
      logic [3:0] nib;
      logic [6:0] segExp;
   } vec_t;
   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0; mDisp = '0; mPend = '0; mDispDp = '0; mPendDp = '0; mPendFlag = 1'b0; mFrame = 1'b0;
   endtask

   task automatic model_edge();
      logic boundary;
      boundary = ((t + 1) % FRAME == 0);
      mFrame   = boundary;
      if (boundary) begin
         if (wrEn) begin
            mDisp = wrData; mDispDp = wrDp;
         end else if (mPendFlag) begin
            mDisp = mPend; mDispDp = mPendDp;
         end
         mPendFlag = 1'b0;
      end else if (wrEn) begin
         mPend = wrData; mPendDp = wrDp; mPendFlag = 1'b1;
      end
      t++;
   endtask

   task automatic expected(output logic [3:0] eSel, output logic [6:0] eSeg, output logic eDp);
      int presc, idx;
      logic blanked;
      presc = t % TD;
      idx   = (t / TD) % ND;
      if (presc < BC) begin
         eSel = 4'hF; eSeg = 7'h7F; eDp = 1'b1;
      end else begin
         blanked = blankLz && (idx > 0) && ((mDisp >> (4 * idx)) == 16'h0);
         eSel = 4'hF ^ (4'b0001 << idx);
         eSeg = blanked ? 7'h7F : ~decTab[mDisp[4*idx +: 4]];
         eDp  = ~mDispDp[idx];
      end
   endtask

   task automatic step();
      logic [3:0] eSel;
      logic [6:0] eSeg;
      logic       eDp;
      @(posedge clk);
      #1;
      model_edge();
      expected(eSel, eSeg, eDp);
      chk("digit_sel", digitSel, eSel);
      chk("seg", seg, eSeg);
      chk("dp", dp, eDp);
      chk("frame_start", frameStart, mFrame);
      chk("pending", pending, mPendFlag);
      wrEn = 1'b0;
   endtask

   task automatic run_to(input int ph);
      int n = 0;
      while ((t % FRAME) != ph && n < 2 * FRAME) begin
         step();
         n++;
      end
      chk("run_to_phase", t % FRAME, ph);
   endtask

   task automatic write(input logic [15:0] d, input logic [3:0] p);
      wrEn = 1'b1; wrData = d; wrDp = p;
      step();
   endtask

   initial begin
      logic [3:0] selTab [4];
      logic [6:0] segTab [4];
      int dpLow, dpBad;

      vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79}; vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
      vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12}; vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
      vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10}; vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
      vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21}; vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};
      selTab = '{4'hE, 4'hD, 4'hB, 4'h7};

      rst = 1'b1; wrEn = 1'b0; wrData = '0; wrDp = '0; blankLz = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sel", digitSel, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_pending", pending, 1'b0);
      chk("rst_frame_start", frameStart, 1'b0);
      rst = 1'b0;
      model_reset();

      // First slot after release: blank for 2 cycles, then digit 0 shows 0.
      step();
      chk("t1_blank_c1", digitSel, 4'hF);
      step();
      chk("t1_sel_c2", digitSel, 4'hE);
      chk("t1_seg_c2", seg, 7'h40);
      repeat (5) step();
      chk("t1_sel_c7", digitSel, 4'hE);

      // Mid-frame write is held until the frame boundary.
      step();
      write(16'h12AF, 4'h0);
      chk("t2_pending", pending, 1'b1);
      step();
      chk("t2_old_seg", seg, 7'h40);
      run_to(0);
      chk("t2_frame_start", frameStart, 1'b1);
      chk("t2_pending_clr", pending, 1'b0);
      segTab = '{7'h0E, 7'h08, 7'h24, 7'h79};
      for (int d = 0; d < ND; d++) begin
         run_to(d * TD + 3);
         chk("t2_sel", digitSel, selTab[d]);
         chk("t2_seg", seg, segTab[d]);
      end

      // Leading-zero blanking keeps the strobe but dark segments.
      blankLz = 1'b1;
      write(16'h0030, 4'h0);
      run_to(0);
      segTab = '{7'h40, 7'h30, 7'h7F, 7'h7F};
      for (int d = 0; d < ND; d++) begin
         run_to(d * TD + 3);
         chk("t3_sel", digitSel, selTab[d]);
         chk("t3_seg", seg, segTab[d]);
      end
      blankLz = 1'b0;

      // A write on the boundary cycle beats an older pending value.
      run_to(5);
      write(16'h9999, 4'h0);
      run_to(FRAME - 1);
      write(16'h5555, 4'h0);
      chk("t4_pending", pending, 1'b0);
      chk("t4_frame_start", frameStart, 1'b1);
      for (int d = 0; d < ND; d++) begin
         run_to(d * TD + 3);
         chk("t4_seg", seg, 7'h12);
      end

      // Decimal point only during the drive phase of digit 2.
      run_to(10);
      write(16'h5555, 4'b0100);
      run_to(0);
      dpLow = 0; dpBad = 0;
      for (int c = 0; c < FRAME; c++) begin
         step();
         if (dp == 1'b0) begin
            dpLow++;
            if ((t % FRAME) < 2 * TD + BC || (t % FRAME) >= 3 * TD) dpBad++;
         end
      end
      chk("t5_dp_low_count", dpLow, 6);
      chk("t5_dp_low_outside", dpBad, 0);

      // Decode table through digits 0 and 1.
      for (int i = 0; i < 16; i++) begin
         write({4{vecs[i].nib}}, 4'h0);
         run_to(0);
         run_to(3);
         chk("tbl_seg_d0", seg, vecs[i].segExp);
         run_to(TD + 3);
         chk("tbl_seg_d1", seg, vecs[i].segExp);
      end

      // Reset during digit 2 drive with a write pending.
      run_to(0);
      write(16'h3333, 4'hF);
      run_to(2 * TD + 4);
      chk("t6_pending_before", pending, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_sel", digitSel, 4'hF);
      chk("t6_seg", seg, 7'h7F);
      chk("t6_dp", dp, 1'b1);
      chk("t6_pending", pending, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int d = 0; d < ND; d++) begin
         run_to(d * TD + 3);
         chk("t6_seg_zero", seg, 7'h40);
         chk("t6_dp_off", dp, 1'b1);
      end

      // Random traffic, with extra writes aimed at the boundary cycle.
      for (int c = 0; c < 1200; c++) begin
         if (c % 50 == 0) blankLz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0 || ((t % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0)) begin
            wrEn = 1'b1;
            for (int k = 0; k < ND; k++) begin
               wrData[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            wrDp = 4'($urandom_range(0, 15));
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
